instr_mem_ctrl: RTL and testbench

Parametrised instruction memory for the fetch stage. It takes byte-addressed fetch requests through a valid/ready handshake and returns one instruction word per accepted request, with a 1-cycle latency. The response is held under backpressure and carries misaligned/out-of-range fault flags. It has a word-write load port for program loading and clears itself with a hardware sweep after reset or on request.

---
 rtl/instr_mem_pkg.sv | 13 +
 rtl/instr_mem_array.sv | 31 +++
 rtl/instr_mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_instr_mem_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the fetch-stage instruction memory.
package instr_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int FAULT_W        = 2;
  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

endpackage

// File: rtl/instr_mem_array.sv
// Simple dual-port synchronous RAM: one write port, one read-first registered read port.
module instr_mem_array #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [XLEN-1:0]  i_wdata,
  input  logic             i_re,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [XLEN-1:0]  o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rdata;

  // Read and write share one process so a same-address access returns the old word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: clear sweep FSM, fetch handshake with fault flags, load port.
module instr_mem_ctrl
  import instr_mem_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  output logic               o_busy,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [ADDR_W-1:0]  i_req_addr,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [XLEN-1:0]    o_rsp_instr,
  output logic [FAULT_W-1:0] o_rsp_fault,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [XLEN-1:0]    i_wr_data
);

  localparam logic [ADDR_W-3:0] DEPTH_WORDS = (ADDR_W-2)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(DEPTH - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [IDX_W-1:0]     r_clr_cnt;
  logic                 r_rsp_valid;
  logic [FAULT_W-1:0]   r_rsp_fault;

  logic                 w_req_ready;
  logic                 w_req_fire;
  logic                 w_req_misalign;
  logic                 w_req_range;
  logic                 w_wr_range;
  logic                 w_clear_go;
  logic                 w_unused_wr_lsb;

  logic                 w_we;
  logic [IDX_W-1:0]     w_waddr;
  logic [XLEN-1:0]      w_wdata;
  logic                 w_re;
  logic [IDX_W-1:0]     w_raddr;
  logic [XLEN-1:0]      w_rdata;

  // Range checks use the whole word index so high address bits never alias into the array.
  assign w_req_misalign  = |i_req_addr[1:0];
  assign w_req_range     = (i_req_addr[ADDR_W-1:2] >= DEPTH_WORDS);
  assign w_wr_range      = (i_wr_addr[ADDR_W-1:2] >= DEPTH_WORDS);
  assign w_unused_wr_lsb = ^i_wr_addr[1:0];

  assign w_clear_go  = (r_state == RUN) && i_clear;
  assign w_req_ready = (r_state == RUN) && !i_clear && (!r_rsp_valid || i_rsp_ready);
  assign w_req_fire  = i_req_valid && w_req_ready;

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    case (r_state)
      CLEAR: begin
        o_busy = 1'b1;
        if (r_clr_cnt == LAST_IDX) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (i_clear) begin
          w_state_next = CLEAR;
        end
      end
      default: w_state_next = CLEAR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= CLEAR;
      r_clr_cnt   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end else if (w_clear_go) begin
        r_clr_cnt <= '0;
      end

      if (w_clear_go) begin
        r_rsp_valid <= 1'b0;
      end else if (w_req_fire) begin
        r_rsp_valid                 <= 1'b1;
        r_rsp_fault[FAULT_MISALIGN] <= w_req_misalign;
        r_rsp_fault[FAULT_RANGE]    <= w_req_range;
      end else if (i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // The sweep owns the write port while clearing; the load port only gets it in RUN.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = i_wr_addr[IDX_W+1:2];
    w_wdata = i_wr_data;
    if (!i_rst) begin
      if (r_state == CLEAR) begin
        w_we    = 1'b1;
        w_waddr = r_clr_cnt;
        w_wdata = '0;
      end else if (i_wr_en && !w_wr_range) begin
        w_we = 1'b1;
      end
    end
  end

  assign w_re    = w_req_fire && !w_req_range;
  assign w_raddr = i_req_addr[IDX_W+1:2];

  instr_mem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // The RAM read register has no reset, so the word is forced to 0 unless a clean response is held.
  assign o_rsp_instr = (r_rsp_valid && (r_rsp_fault == '0)) ? w_rdata : '0;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_fault = r_rsp_fault;
  assign o_req_ready = w_req_ready;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl with a word-level reference model checked every cycle.
module tb_instr_mem_ctrl;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_clear;
  logic              o_busy;
  logic              i_req_valid;
  logic              o_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic [XLEN-1:0]   o_rsp_instr;
  logic [1:0]        o_rsp_fault;
  logic              i_wr_en;
  logic [ADDR_W-1:0] i_wr_addr;
  logic [XLEN-1:0]   i_wr_data;

  always #5 i_clk = ~i_clk;

  instr_mem_ctrl #(
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_clear),
    .o_busy      (o_busy),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr  (i_req_addr),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_instr (o_rsp_instr),
    .o_rsp_fault (o_rsp_fault),
    .i_wr_en     (i_wr_en),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain word array, a busy-cycle budget and one pending response.
  logic [31:0] m_mem [DEPTH];
  int          m_busy_left = DEPTH;
  bit          m_valid = 1'b0;
  logic [31:0] m_instr = '0;
  logic [1:0]  m_fault = '0;
  bit          chk_en = 1'b0;

  always @(posedge i_clk) begin : model_proc
    logic [29:0] ridx;
    logic [29:0] widx;
    bit          mis;
    bit          rng;
    if (i_rst) begin
      chk_en      = 1'b1;
      m_busy_left = DEPTH;
      m_valid     = 1'b0;
      for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (i_clear) begin
      m_valid     = 1'b0;
      m_busy_left = DEPTH;
      for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
    end else begin
      ridx = i_req_addr[31:2];
      if (i_req_valid && (!m_valid || i_rsp_ready)) begin
        mis     = (i_req_addr[1:0] != 2'b00);
        rng     = (ridx >= DEPTH);
        m_fault = {rng, mis};
        m_instr = (mis || rng) ? 32'h0 : m_mem[int'(ridx)];
        m_valid = 1'b1;
      end else if (i_rsp_ready) begin
        m_valid = 1'b0;
      end
      widx = i_wr_addr[31:2];
      if (i_wr_en && (widx < DEPTH)) m_mem[int'(widx)] = i_wr_data;
    end
  end

  always @(negedge i_clk) begin : cmp_proc
    logic ready_exp;
    if (chk_en) begin
      ready_exp = (m_busy_left == 0) && !i_clear && (!m_valid || i_rsp_ready);
      check("model_busy", 32'(o_busy), 32'(m_busy_left > 0));
      check("model_ready", 32'(o_req_ready), 32'(ready_exp));
      check("model_rsp_valid", 32'(o_rsp_valid), 32'(m_valid));
      if (m_valid) begin
        check("model_rsp_instr", o_rsp_instr, m_instr);
        check("model_rsp_fault", 32'(o_rsp_fault), 32'(m_fault));
      end
      if (o_rsp_valid && i_rsp_ready)
        $display("rsp   t=%0t instr=%h fault=%b", $time, o_rsp_instr, o_rsp_fault);
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    i_wr_en = 1'b1; i_wr_addr = addr; i_wr_data = data;
    @(posedge i_clk); #1;
    i_wr_en = 1'b0;
    $display("write addr=%h data=%h", addr, data);
  endtask

  task automatic fetch_expect(input string name, input logic [31:0] addr,
                              input logic [31:0] exp_instr, input logic [1:0] exp_fault);
    int n = 0;
    i_req_valid = 1'b1; i_req_addr = addr; i_rsp_ready = 1'b1;
    @(negedge i_clk);
    while (!o_req_ready && n < 100) begin
      n++;
      @(negedge i_clk);
    end
    check({name, "_accept"}, 32'(o_req_ready), 32'd1);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(negedge i_clk);
    check({name, "_valid"}, 32'(o_rsp_valid), 32'd1);
    check({name, "_instr"}, o_rsp_instr, exp_instr);
    check({name, "_fault"}, 32'(o_rsp_fault), 32'(exp_fault));
    $display("fetch addr=%h instr=%h fault=%b", addr, o_rsp_instr, o_rsp_fault);
    @(posedge i_clk); #1;
  endtask

  task automatic count_busy(input bit wr_mid, output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge i_clk);
      if (!o_busy) break;
      n++;
      check("busy_ready_low", 32'(o_req_ready), 32'd0);
      @(posedge i_clk); #1;
      i_wr_en   = wr_mid && (n == 30);
      i_wr_addr = 32'h4;
      i_wr_data = 32'hAAAA5555;
    end
    i_wr_en = 1'b0;
    @(posedge i_clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hs;
    i_rst = 1'b1; i_clear = 1'b0; i_req_valid = 1'b0; i_req_addr = '0;
    i_rsp_ready = 1'b1; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;

    // 1: reset values, sweep length, cleared contents
    @(posedge i_clk); @(posedge i_clk); #1;
    @(negedge i_clk);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_instr", o_rsp_instr, 32'd0);
    check("rst_rsp_fault", 32'(o_rsp_fault), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd1);
    check("rst_ready", 32'(o_req_ready), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    count_busy(1'b0, n);
    check("init_busy_len", 32'(n), 32'd64);
    fetch_expect("init_0x0", 32'h0, 32'h0, 2'b00);
    fetch_expect("init_0x4", 32'h4, 32'h0, 2'b00);
    fetch_expect("init_0xfc", 32'hFC, 32'h0, 2'b00);

    // 2: load two words, fetch them back-to-back
    wr(32'h8, 32'h00500093);
    wr(32'hC, 32'h00A00113);
    i_rsp_ready = 1'b1; i_req_valid = 1'b1; i_req_addr = 32'h8;
    @(posedge i_clk); #1;
    i_req_addr = 32'hC;
    @(negedge i_clk);
    check("b2b_first_instr", o_rsp_instr, 32'h00500093);
    check("b2b_second_ready", 32'(o_req_ready), 32'd1);
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    @(negedge i_clk);
    check("b2b_second_valid", 32'(o_rsp_valid), 32'd1);
    check("b2b_second_instr", o_rsp_instr, 32'h00A00113);
    @(posedge i_clk); #1;

    // 3: backpressure holds the response and blocks the next request
    i_rsp_ready = 1'b0; i_req_valid = 1'b1; i_req_addr = 32'h8;
    @(posedge i_clk); #1;
    i_req_addr = 32'hC;
    hs = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("hold_ready", 32'(o_req_ready), 32'd0);
      check("hold_instr", o_rsp_instr, 32'h00500093);
      if (o_rsp_valid && i_rsp_ready) hs++;
      @(posedge i_clk); #1;
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    check("release_ready", 32'(o_req_ready), 32'd1);
    check("release_instr", o_rsp_instr, 32'h00500093);
    if (o_rsp_valid && i_rsp_ready) hs++;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    check("hold_handshakes", 32'(hs), 32'd1);
    @(negedge i_clk);
    check("release_next_instr", o_rsp_instr, 32'h00A00113);
    @(posedge i_clk); #1;

    // 4: fault flags and out-of-range writes
    fetch_expect("mis_0x6", 32'h6, 32'h0, 2'b01);
    fetch_expect("mis_0xa", 32'hA, 32'h0, 2'b01);
    fetch_expect("rng_0x100", 32'h100, 32'h0, 2'b10);
    fetch_expect("both_0x102", 32'h102, 32'h0, 2'b11);
    fetch_expect("rng_high", 32'h80000008, 32'h0, 2'b10);
    wr(32'h100, 32'h12345678);
    wr(32'h80000008, 32'h87654321);
    fetch_expect("noalias_0x0", 32'h0, 32'h0, 2'b00);
    fetch_expect("noalias_0x8", 32'h8, 32'h00500093, 2'b00);

    // 5: same-cycle read and write returns old data
    wr(32'h10, 32'h00000013);
    i_rsp_ready = 1'b1; i_req_valid = 1'b1; i_req_addr = 32'h10;
    i_wr_en = 1'b1; i_wr_addr = 32'h10; i_wr_data = 32'hDEADBEEF;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0; i_wr_en = 1'b0;
    @(negedge i_clk);
    check("rw_old_instr", o_rsp_instr, 32'h00000013);
    @(posedge i_clk); #1;
    fetch_expect("rw_new", 32'h10, 32'hDEADBEEF, 2'b00);

    // 6a: clear with a response pending
    i_rsp_ready = 1'b0; i_req_valid = 1'b1; i_req_addr = 32'h8;
    @(posedge i_clk); #1;
    i_clear = 1'b1; i_req_addr = 32'hC;
    @(negedge i_clk);
    check("clear_ready_low", 32'(o_req_ready), 32'd0);
    check("clear_pending_valid", 32'(o_rsp_valid), 32'd1);
    @(posedge i_clk); #1;
    i_clear = 1'b0; i_req_valid = 1'b0; i_rsp_ready = 1'b1;
    @(negedge i_clk);
    check("clear_rsp_dropped", 32'(o_rsp_valid), 32'd0);
    check("clear_busy", 32'(o_busy), 32'd1);
    @(posedge i_clk); #1;
    count_busy(1'b1, n);
    check("clear_busy_len", 32'(n + 1), 32'd64);
    fetch_expect("clr_0x8", 32'h8, 32'h0, 2'b00);
    fetch_expect("clr_0xc", 32'hC, 32'h0, 2'b00);
    fetch_expect("clr_0x10", 32'h10, 32'h0, 2'b00);
    fetch_expect("clr_drop_wr_0x4", 32'h4, 32'h0, 2'b00);

    // 6b: reset at sweep count 20, with a write in the reset cycle
    wr(32'h8, 32'h00500093);
    fetch_expect("pre_rst_0x8", 32'h8, 32'h00500093, 2'b00);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    repeat (20) @(posedge i_clk);
    #1;
    i_rst = 1'b1; i_wr_en = 1'b1; i_wr_addr = 32'h8; i_wr_data = 32'h55;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_wr_en = 1'b0;
    @(negedge i_clk);
    check("midrst_busy", 32'(o_busy), 32'd1);
    check("midrst_valid", 32'(o_rsp_valid), 32'd0);
    check("midrst_ready", 32'(o_req_ready), 32'd0);
    @(posedge i_clk); #1;
    count_busy(1'b0, n);
    check("midrst_busy_len", 32'(n + 1), 32'd64);
    fetch_expect("midrst_0x8", 32'h8, 32'h0, 2'b00);
    fetch_expect("midrst_0x10", 32'h10, 32'h0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
